pwm_multi: RTL and testbench

//   NCH-channel PWM generator sharing one period counter; parametrised successor of the single-channel pwm.
//   Per-channel compare values plus the shared period are double-buffered (shadow -> active), so updates

---
 rtl/pwm_multi.sv | 130 +++++++++++++
 tb/tb_pwm_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, double-buffered period/compare set.
// Define PWM_MULTI_CENTER_EN to add the center-aligned (up/down counting) mode and its center port.
module pwm_multi #(
  parameter int XLEN = 3,
  parameter int NCH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                upd,
  input  logic [XLEN-1:0]     period,
  input  logic [NCH*XLEN-1:0] ampl,
`ifdef PWM_MULTI_CENTER_EN
  input  logic                center,
`endif
  output logic [NCH-1:0]      signal,
  output logic                sync
);

  // Same bit layout as the flat ampl port: channel i sits at [i*XLEN +: XLEN].
  typedef logic [NCH-1:0][XLEN-1:0] ampl_set_t;

  logic [XLEN-1:0] cnt;
  logic [XLEN-1:0] cnt_nxt;
  logic [XLEN-1:0] period_act;
  logic [XLEN-1:0] sh_period;
  logic [XLEN-1:0] src_period;
  logic [XLEN-1:0] period_m1;
  ampl_set_t       ampl_act;
  ampl_set_t       sh_ampl;
  ampl_set_t       src_ampl;
  logic [NCH-1:0]  signal_nxt;
  logic            sync_nxt;
  logic            boundary;
  logic            is_idle;
  logic            at_top;
  logic            dir_up;

`ifdef PWM_MULTI_CENTER_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  dir_t dir;
  dir_t dir_nxt;
  logic center_act;
  logic sh_center;
  logic src_center;

  assign src_center = upd ? center : sh_center;
`endif

  assign period_m1  = period_act - XLEN'(1);
  assign is_idle    = (period_act == '0);
  assign at_top     = (cnt == period_m1);
  // An update strobe on the loading edge bypasses the shadow so new values win immediately.
  assign src_period = upd ? period : sh_period;
  assign src_ampl   = upd ? ampl_set_t'(ampl) : sh_ampl;

  // Next-state and output decode for the counter / direction machine.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    cnt_nxt = cnt;
`ifdef PWM_MULTI_CENTER_EN
    dir_nxt  = dir;
    dir_up   = (dir == DIR_UP);
    boundary = is_idle || (center_act ? (dir == DIR_DOWN && cnt == '0) : at_top);
    if (boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!center_act) begin
      cnt_nxt = cnt + XLEN'(1);
    end else if (dir_up) begin
      // The top value is held for a second cycle while the direction turns around.
      if (at_top) dir_nxt = DIR_DOWN;
      else        cnt_nxt = cnt + XLEN'(1);
    end else begin
      cnt_nxt = cnt - XLEN'(1);
    end
`else
    dir_up   = 1'b1;
    boundary = is_idle || at_top;
    if (boundary) cnt_nxt = '0;
    else          cnt_nxt = cnt + XLEN'(1);
`endif
    for (int i = 0; i < NCH; i++) begin
      signal_nxt[i] = !is_idle && (cnt < ampl_act[i]);
    end
    sync_nxt = !is_idle && (cnt == '0) && dir_up;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt        <= '0;
      period_act <= '0;
      ampl_act   <= '0;
      sh_period  <= '0;
      sh_ampl    <= '0;
      signal     <= '0;
      sync       <= 1'b0;
`ifdef PWM_MULTI_CENTER_EN
      dir        <= DIR_UP;
      center_act <= 1'b0;
      sh_center  <= 1'b0;
`endif
    end else begin
      if (upd) begin
        sh_period <= period;
        sh_ampl   <= ampl_set_t'(ampl);
`ifdef PWM_MULTI_CENTER_EN
        sh_center <= center;
`endif
      end
      if (en) begin
        cnt    <= cnt_nxt;
        signal <= signal_nxt;
        sync   <= sync_nxt;
`ifdef PWM_MULTI_CENTER_EN
        dir    <= dir_nxt;
`endif
        if (boundary) begin
          period_act <= src_period;
          ampl_act   <= src_ampl;
`ifdef PWM_MULTI_CENTER_EN
          center_act <= src_center;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: start-up vector table, hand-written corner sequences and a random run
// compared against a phase-index model of the PWM period.
module tb_pwm_multi;

  // XLEN=4 so a compare value of 9 (above the period of 7) is representable.
  localparam int XL = 4;
  localparam int NC = 4;

  logic           clk;
  logic           rst;
  logic           en;
  logic           upd;
  logic [XL-1:0]  period;
  logic [NC*XL-1:0] ampl;
  logic           center;
  logic [NC-1:0]  signal;
  logic           sync;

  int total = 0;
  int bad   = 0;

  pwm_multi #(.XLEN(XL), .NCH(NC)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .upd    (upd),
    .period (period),
    .ampl   (ampl),
`ifdef PWM_MULTI_CENTER_EN
    .center (center),
`endif
    .signal (signal),
    .sync   (sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: position k inside a period of length P (edge) or 2P (center).
  int           m_p, m_k, s_p;
  int           m_amp [NC];
  int           s_amp [NC];
  bit           m_c, s_c;
  logic [NC-1:0] m_sig;
  logic         m_sync;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int len;
    int c;
    if (rst) begin
      m_p = 0; m_k = 0; s_p = 0; m_c = 0; s_c = 0; m_sig = '0; m_sync = 1'b0;
      for (int ch = 0; ch < NC; ch++) begin
        m_amp[ch] = 0;
        s_amp[ch] = 0;
      end
    end else begin
      if (en) begin
        len = m_c ? 2 * m_p : m_p;
        c   = (m_c && m_k >= m_p) ? (2 * m_p - 1 - m_k) : m_k;
        for (int ch = 0; ch < NC; ch++) m_sig[ch] = (m_p != 0) && (c < m_amp[ch]);
        m_sync = (m_p != 0) && (m_k == 0);
        if (m_p == 0 || m_k == len - 1) begin
          m_k = 0;
          if (upd) begin
            m_p = int'(period); m_c = center;
            for (int ch = 0; ch < NC; ch++) m_amp[ch] = int'(ampl[ch*XL +: XL]);
          end else begin
            m_p = s_p; m_c = s_c;
            for (int ch = 0; ch < NC; ch++) m_amp[ch] = s_amp[ch];
          end
        end else begin
          m_k++;
        end
      end
      if (upd) begin
        s_p = int'(period); s_c = center;
        for (int ch = 0; ch < NC; ch++) s_amp[ch] = int'(ampl[ch*XL +: XL]);
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model, sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic u, input logic e,
                      input logic [XL-1:0] p, input logic [NC*XL-1:0] a, input logic c);
    @(negedge clk);
    rst = r; upd = u; en = e; period = p; ampl = a; center = c;
    model_step();
    @(posedge clk);
    #1;
    check("model_signal", 32'(signal), 32'(m_sig));
    check("model_sync", 32'(sync), 32'(m_sync));
  endtask

  typedef struct {
    logic          rst;
    logic          upd;
    logic          en;
    logic [XL-1:0] period;
    logic [NC*XL-1:0] ampl;
    logic [NC-1:0] exp_sig;
    logic          exp_sync;
  } vec_t;

  vec_t tbl [10];
  logic [0:13] e3;
  logic [0:12] e4_ch1;
  logic [0:12] e4_sync;
  logic [0:7]  e6;

  initial begin
    rst = 1'b1; upd = 1'b0; en = 1'b0; period = '0; ampl = '0; center = 1'b0;
    model_step();

    // Start-up with ch0=7 ch1=4 ch2=1 ch3=9, period 7.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 4'd7, 16'h9147, 4'h0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'hF, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'hB, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'hB, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'hB, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'h9, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'h9, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'h9, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 4'hF, 1'b1};
    e3      = 14'b1111000_1100000;
    e4_ch1  = 13'b1111111000001;
    e4_sync = 13'b1000000000001;
    e6      = 8'b11000011;

    // All compare values zero: outputs stay low, sync every 7 cycles.
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("t1_reset_sig", 32'(signal), 32'h0);
    check("t1_reset_sync", 32'(sync), 32'h0);
    step(1'b0, 1'b1, 1'b1, 4'd7, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd7, 16'h0, 1'b0);
      check("t1_sig", 32'(signal), 32'h0);
      check("t1_sync", 32'(sync), 32'((i % 7) == 0));
    end

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].upd, tbl[i].en, tbl[i].period, tbl[i].ampl, 1'b0);
      check($sformatf("t2_sig_row%0d", i), 32'(signal), 32'(tbl[i].exp_sig));
      check($sformatf("t2_sync_row%0d", i), 32'(sync), 32'(tbl[i].exp_sync));
    end

    // Mid-period update of ch1 to 2 lands only at the next period.
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd7, 16'h9147, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, i == 3, 1'b1, 4'd7, 16'h9127, 1'b0);
      check($sformatf("t3_ch1_%0d", i), 32'(signal[1]), 32'(e3[i]));
    end

    // Five-cycle enable gap at cnt=2 freezes outputs without losing phase.
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b0, !(i >= 2 && i <= 6), 4'd7, 16'h0, 1'b0);
      check($sformatf("t4_ch1_%0d", i), 32'(signal[1]), 32'(e4_ch1[i]));
      check($sformatf("t4_sync_%0d", i), 32'(sync), 32'(e4_sync[i]));
    end

    // Reset at cnt=4 wins over en/upd and leaves the block idle.
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd7, 16'h9147, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd7, 16'h0, 1'b0);
    check("t5_pre_rst_sig", 32'(signal), 32'hB);
    step(1'b1, 1'b1, 1'b1, 4'd7, 16'hFFFF, 1'b0);
    check("t5_rst_sig", 32'(signal), 32'h0);
    check("t5_rst_sync", 32'(sync), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd7, 16'hFFFF, 1'b0);
      check("t5_idle_sig", 32'(signal), 32'h0);
      check("t5_idle_sync", 32'(sync), 32'h0);
    end

`ifdef PWM_MULTI_CENTER_EN
    // Center-aligned: period 4, compare 2 gives 11000011, sync once per 8 cycles.
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd4, 16'h2222, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd4, 16'h0, 1'b0);
      check($sformatf("t6_sig_%0d", i), 32'(signal), e6[i % 8] ? 32'hF : 32'h0);
      check($sformatf("t6_sync_%0d", i), 32'(sync), 32'((i % 8) == 0));
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic r, u, e, c;
      logic [XL-1:0] p;
      logic [NC*XL-1:0] a;
      r = ($urandom_range(0, 59) == 0);
      u = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 3) != 0);
      p = XL'($urandom_range(0, 9));
      a = (NC*XL)'($urandom);
`ifdef PWM_MULTI_CENTER_EN
      c = 1'($urandom_range(0, 1));
`else
      c = 1'b0;
`endif
      step(r, u, e, p, a, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
